// File: rtl/bin_to_bcd_sequencer.sv
// Feeds a parallel binary word MSB-first into a serial shift-add-3 BCD converter, then captures its result.
// Define BCD_SEQ_CLEAR_EN to prefix each conversion with a 4*DIGITS-cycle zero flush of the converter.
module bin_to_bcd_sequencer #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 11
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  bit_out,
  output logic                  shift_en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done
);

`ifdef BCD_SEQ_CLEAR_EN
  localparam int CLEAR_LEN = 4 * DIGITS;
  localparam int CNT_MAX   = (CLEAR_LEN > WIDTH) ? CLEAR_LEN : WIDTH;
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, CAPTURE} state_t;
`else
  localparam int CNT_MAX   = WIDTH;
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      busy     <= 1'b0;
      bit_out  <= 1'b0;
      shift_en <= 1'b0;
      bcd_out  <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            shift_en <= 1'b1;
`ifdef BCD_SEQ_CLEAR_EN
            state    <= CLEAR;
            cnt      <= CW'(CLEAR_LEN);
            sreg     <= bin_in;
            bit_out  <= 1'b0;
`else
            // First operand bit goes out in the very next cycle.
            state    <= SHIFT;
            cnt      <= CW'(WIDTH);
            sreg     <= {bin_in[WIDTH-2:0], 1'b0};
            bit_out  <= bin_in[WIDTH-1];
`endif
          end
        end
`ifdef BCD_SEQ_CLEAR_EN
        CLEAR: begin
          if (cnt == CW'(1)) begin
            state   <= SHIFT;
            cnt     <= CW'(WIDTH);
            bit_out <= sreg[WIDTH-1];
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
          end else begin
            cnt     <= cnt - CW'(1);
            bit_out <= 1'b0;
          end
        end
`endif
        SHIFT: begin
          if (cnt == CW'(1)) begin
            state    <= CAPTURE;
            cnt      <= '0;
            shift_en <= 1'b0;
            bit_out  <= 1'b0;
          end else begin
            cnt     <= cnt - CW'(1);
            bit_out <= sreg[WIDTH-1];
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
          end
        end
        CAPTURE: begin
          // Converter output now reflects the final shift.
          bcd_out <= bcd_in;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// Bench for bin_to_bcd_sequencer: drives bcd_in from a double-dabble converter model, checks against decimal arithmetic.
module tb_bin_to_bcd_sequencer;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 11;
  localparam int BW     = 4 * DIGITS;
`ifdef BCD_SEQ_CLEAR_EN
  localparam int CLR = BW;
`else
  localparam int CLR = 0;
`endif
  localparam int SH_LEN = CLR + WIDTH;
  localparam int LAT    = SH_LEN + 2;
  localparam int RST_C  = CLR + 6;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy, bit_out, shift_en, done;
  logic [BW-1:0]    bcd_in, bcd_out;

  logic [BW-1:0]    conv;
  logic             conv_ld;
  logic [BW-1:0]    conv_ld_val;

  int errs = 0;
  int checks = 0;

  bin_to_bcd_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .bin_in(bin_in),
    .busy(busy), .bit_out(bit_out), .shift_en(shift_en),
    .bcd_in(bcd_in), .bcd_out(bcd_out), .done(done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] q, input logic b);
    for (int d = 0; d < DIGITS; d++)
      if (q[4*d +: 4] >= 4'd5) q[4*d +: 4] = q[4*d +: 4] + 4'd3;
    return {q[BW-2:0], b};
  endfunction

  // Downstream converter: not affected by the sequencer's Reset.
  always @(posedge Clk) begin
    if (conv_ld) conv <= conv_ld_val;
    else if (shift_en) conv <= dabble(conv, bit_out);
  end
  assign bcd_in = conv;

  function automatic logic [BW-1:0] to_bcd(input longint unsigned v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_bcd();
    logic [BW-1:0] g;
    for (int d = 0; d < DIGITS; d++) g[4*d +: 4] = 4'($urandom_range(0, 9));
    return g;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [WIDTH-1:0] v);
    bin_in = v;
    start  = 1'b1;
`ifndef BCD_SEQ_CLEAR_EN
    conv_ld     = 1'b1;
    conv_ld_val = '0;
`endif
    tick();
    start   = 1'b0;
    conv_ld = 1'b0;
  endtask

  task automatic run(input logic [WIDTH-1:0] v, input bit started, input int inj_cyc,
                     input int rst_cyc, input bit chain, input logic [WIDTH-1:0] nxt,
                     output int done_cyc, output int en_cnt, output int busy_cnt,
                     output int dones, output logic [BW-1:0] res, output bit bits_ok);
    logic exp_b;
    done_cyc = -1; en_cnt = 0; busy_cnt = 0; dones = 0; res = '0; bits_ok = 1'b1;
    if (!started) launch(v);
    for (int c = 1; c <= LAT + 3; c++) begin
      if (c == rst_cyc) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      if (shift_en) begin
        if (en_cnt >= SH_LEN) bits_ok = 1'b0;
        else begin
          exp_b = (en_cnt < CLR) ? 1'b0 : v[WIDTH-1-(en_cnt-CLR)];
          if (bit_out !== exp_b) bits_ok = 1'b0;
        end
        en_cnt++;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = bcd_out;
          if (chain) begin
            launch(nxt);
            return;
          end
        end
      end
      if (c == inj_cyc) begin
        bin_in = 7;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic do_conv(input string tag, input logic [WIDTH-1:0] v, input bit started,
                         input int inj_cyc, input bit chain, input logic [WIDTH-1:0] nxt);
    int dc, ec, bc, dn;
    logic [BW-1:0] res;
    bit bok;
    run(v, started, inj_cyc, -1, chain, nxt, dc, ec, bc, dn, res, bok);
    chk($sformatf("%s_done_cyc", tag), 64'(dc), 64'(LAT));
    chk($sformatf("%s_bcd", tag), 64'(res), 64'(to_bcd(64'(v))));
    chk($sformatf("%s_en_cnt", tag), 64'(ec), 64'(SH_LEN));
    chk($sformatf("%s_busy_cnt", tag), 64'(bc), 64'(LAT - 1));
    chk($sformatf("%s_bits", tag), 64'(bok), 64'(1));
    if (!chain) begin
      chk($sformatf("%s_dones", tag), 64'(dn), 64'(1));
      chk($sformatf("%s_held", tag), 64'(bcd_out), 64'(to_bcd(64'(v))));
    end
  endtask

  initial begin
    int dc, ec, bc, dn;
    logic [BW-1:0] res;
    bit bok;
    logic [WIDTH-1:0] r;

    Reset = 1'b1; start = 1'b0; bin_in = '0;
    conv_ld = 1'b1; conv_ld_val = rnd_bcd();
    tick();
    tick();
    conv_ld = 1'b0;
    Reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_shift_en", 64'(shift_en), 64'(0));
    chk("rst_bit_out", 64'(bit_out), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bcd_out", 64'(bcd_out), 64'(0));
    tick();

    do_conv("b255", 255, 1'b0, -1, 1'b0, '0);
    do_conv("ones", 32'hFFFF_FFFF, 1'b0, -1, 1'b0, '0);
    do_conv("inj", $urandom, 1'b0, CLR + 10, 1'b0, '0);

    r = $urandom;
    do_conv("chain_a", r, 1'b0, -1, 1'b1, 1000);
    do_conv("chain_b", 1000, 1'b1, -1, 1'b0, '0);

    run($urandom, 1'b0, -1, RST_C, 1'b0, '0, dc, ec, bc, dn, res, bok);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_shift_en", 64'(shift_en), 64'(0));
    chk("midrst_bit_out", 64'(bit_out), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_bcd_out", 64'(bcd_out), 64'(0));
    conv_ld = 1'b1; conv_ld_val = rnd_bcd();
    tick();
    conv_ld = 1'b0;
    do_conv("after_rst", 12345, 1'b0, -1, 1'b0, '0);

    do_conv("zero", 0, 1'b0, -1, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      r = (i % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 99999));
      do_conv($sformatf("rnd%0d", i), r, 1'b0, -1, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
